int_seq: RTL

Interrupt sequencer between the interrupt controller and the CPU core. Accepts the registered `irq` level and the priority-encoded handler address `EAddr`, then waits for a safe instruction boundary. At that boundary it saves the return PC, redirects fetch to the handler, and acknowledges the controller with `iack`. It masks further interrupts until the handler executes `eret`, then redirects fetch back to the saved PC.

---
 rtl/int_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/int_seq.sv
// Interrupt sequencer: waits for a safe instruction boundary, redirects fetch
// to the handler, masks nesting until eret, then redirects back to the saved PC.
module int_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic [31:0] EAddr,
  input  logic        ie,
  input  logic        boundary,
  input  logic [31:0] pc_next,
  input  logic        eret,
  output logic        take_int,
  output logic [31:0] vector,
  output logic        iack,
  output logic        ret_int,
  output logic [31:0] epc,
  output logic        in_isr,
  output logic [15:0] int_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PEND = 3'd1,
    S_TAKE = 3'd2,
    S_ISR  = 3'd3,
    S_RET  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_capture;
  logic [31:0] r_vector;
  logic [31:0] r_epc;
  logic [15:0] r_count;

  // State register; reset aborts any in-flight sequence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; capture happens only on the PEND->TAKE edge
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (irq && ie) begin
          w_next = S_PEND;
        end
      end
      S_PEND: begin
        // A withdrawn request wins over a coincident boundary
        if (!irq || !ie) begin
          w_next = S_IDLE;
        end else if (boundary) begin
          w_next    = S_TAKE;
          w_capture = 1'b1;
        end
      end
      S_TAKE: begin
        w_next = S_ISR;
      end
      S_ISR: begin
        if (eret) begin
          w_next = S_RET;
        end
      end
      S_RET: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Handler address, return PC and take counter; hold outside the capture edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vector <= '0;
      r_epc    <= '0;
      r_count  <= '0;
    end else if (w_capture) begin
      r_vector <= EAddr;
      r_epc    <= pc_next;
      r_count  <= r_count + 16'd1;
    end
  end

  // Pulses and status are pure state decode, so they drop with reset at once
  always_comb begin
    take_int  = (r_state == S_TAKE);
    iack      = (r_state == S_TAKE);
    ret_int   = (r_state == S_RET);
    in_isr    = (r_state == S_TAKE) || (r_state == S_ISR) || (r_state == S_RET);
    vector    = r_vector;
    epc       = r_epc;
    int_count = r_count;
  end

endmodule
